// File: rtl/multicycle_ctrl_if.sv
// Memory port bundle between the multi-cycle controller and the unified
// instruction/data memory. The controller is the master of the request side.
interface multicycle_ctrl_if;
  logic       mem_req;
  logic       mem_wen;
  logic [3:0] mem_wstrb;
  logic       mem_iord;
  logic       mem_ready;

  modport master (
    output mem_req,
    output mem_wen,
    output mem_wstrb,
    output mem_iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_wen,
    input  mem_wstrb,
    input  mem_iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the MIPS core. Sequences the shared datapath
// and the single memory port over several cycles per instruction (R-type, lw,
// sw, beq, j, addiu) and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W          = 32,
  parameter bit FETCH_ADDR_SEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_if.master    mem,
  input  logic [5:0]           opcode_i,
  input  logic                 alu_zero_i,
  output logic                 ir_wen_o,
  output logic                 mdr_wen_o,
  output logic                 pc_wen_o,
  output logic [1:0]           pc_src_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           alu_op_o,
  output logic                 rf_wen_o,
  output logic                 rf_dst_o,
  output logic                 rf_data_mem_o,
  output logic                 illegal_o,
  output logic [CNT_W-1:0]     retired_o,
  output logic [3:0]           state_dbg_o
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IEXEC  = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  logic       req, wen, iord, ir_wen, mdr_wen, pc_wen, rf_wen, rf_dst, rf_dm, illegal;
  logic [3:0] wstrb;
  logic [1:0] pc_src, alu_b, alu_op;
  logic       alu_a;

  // Next state, and the retire pulse on every transition that ends an instruction.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDIU:     state_d = S_IEXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  if (mem.mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXEC:   state_d = S_RWB;
      S_RWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  // Per-state datapath controls; strobes are held low for as long as reset is high.
  always_comb begin
    req = 1'b0; wen = 1'b0; wstrb = 4'b0000; iord = 1'b0;
    ir_wen = 1'b0; mdr_wen = 1'b0; pc_wen = 1'b0; pc_src = 2'b00;
    alu_a = 1'b0; alu_b = 2'b00; alu_op = 2'b00;
    rf_wen = 1'b0; rf_dst = 1'b0; rf_dm = 1'b0; illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1; iord = FETCH_ADDR_SEL; alu_b = 2'b01;
        ir_wen = mem.mem_ready; pc_wen = mem.mem_ready;
      end
      S_DECODE: alu_b = 2'b11;
      S_MEMADR: begin alu_a = 1'b1; alu_b = 2'b10; end
      S_MEMRD:  begin req = 1'b1; iord = ~FETCH_ADDR_SEL; mdr_wen = mem.mem_ready; end
      S_MEMWB:  begin rf_wen = 1'b1; rf_dm = 1'b1; end
      S_MEMWR:  begin req = 1'b1; wen = 1'b1; wstrb = 4'b1111; iord = ~FETCH_ADDR_SEL; end
      S_EXEC:   begin alu_a = 1'b1; alu_op = 2'b10; end
      S_RWB:    begin rf_wen = 1'b1; rf_dst = 1'b1; end
      S_IEXEC:  begin alu_a = 1'b1; alu_b = 2'b10; end
      S_IWB:    rf_wen = 1'b1;
      S_BRANCH: begin alu_a = 1'b1; alu_op = 2'b01; pc_src = 2'b01; pc_wen = alu_zero_i; end
      S_JUMP:   begin pc_wen = 1'b1; pc_src = 2'b10; end
      S_TRAP:   illegal = 1'b1;
      default:  ;
    endcase
    if (rst) begin
      req = 1'b0; wen = 1'b0; wstrb = 4'b0000;
      ir_wen = 1'b0; mdr_wen = 1'b0; pc_wen = 1'b0; rf_wen = 1'b0; illegal = 1'b0;
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign mem.mem_req    = req;
  assign mem.mem_wen    = wen;
  assign mem.mem_wstrb  = wstrb;
  assign mem.mem_iord   = iord;
  assign ir_wen_o       = ir_wen;
  assign mdr_wen_o      = mdr_wen;
  assign pc_wen_o       = pc_wen;
  assign pc_src_o       = pc_src;
  assign alu_src_a_o    = alu_a;
  assign alu_src_b_o    = alu_b;
  assign alu_op_o       = alu_op;
  assign rf_wen_o       = rf_wen;
  assign rf_dst_o       = rf_dst;
  assign rf_data_mem_o  = rf_dm;
  assign illegal_o      = illegal;
  assign retired_o      = retired_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction runs with
// literal expectations, then randomized traffic checked every cycle against an
// instruction-sequence model.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDIU = 6'b001001;

  typedef enum int {PH_F, PH_D, PH_A, PH_RD, PH_LWB, PH_WR, PH_EX, PH_RWB,
                    PH_IEX, PH_IWB, PH_BR, PH_JMP, PH_TRAP} phase_t;
  typedef enum int {C_R, C_LW, C_SW, C_BEQ, C_J, C_ADDIU, C_ILL} cls_t;

  typedef struct packed {
    logic req, wen; logic [3:0] wstrb; logic iord, ir, mdr, pcw;
    logic [1:0] pcs; logic rf, dst, dm, ill;
  } strobes_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        aluZero = 1'b0;
  logic        memReady = 1'b0;
  logic        irWen, mdrWen, pcWen, aluSrcA, rfWen, rfDst, rfDataMem, illegal;
  logic [1:0]  pcSrc, aluSrcB, aluOp;
  logic [31:0] retired;
  logic [3:0]  stateDbg;

  int vectors = 0;
  int miscompares = 0;

  cls_t        mCls = C_R;
  int          mIdx = 0;
  logic [31:0] mRetired = '0;

  always #5 clk = ~clk;

  multicycle_ctrl_if memIf ();
  assign memIf.mem_ready = memReady;

  multicycle_ctrl #(.CNT_W(32), .FETCH_ADDR_SEL(1'b0)) dut (
    .clk(clk), .rst(rst), .mem(memIf.master),
    .opcode_i(opcode), .alu_zero_i(aluZero),
    .ir_wen_o(irWen), .mdr_wen_o(mdrWen), .pc_wen_o(pcWen), .pc_src_o(pcSrc),
    .alu_src_a_o(aluSrcA), .alu_src_b_o(aluSrcB), .alu_op_o(aluOp),
    .rf_wen_o(rfWen), .rf_dst_o(rfDst), .rf_data_mem_o(rfDataMem),
    .illegal_o(illegal), .retired_o(retired), .state_dbg_o(stateDbg)
  );

  function automatic cls_t classify(logic [5:0] op);
    case (op)
      OP_R:         return C_R;
      OP_LW:        return C_LW;
      OP_SW:        return C_SW;
      OP_BEQ:       return C_BEQ;
      OP_J:         return C_J;
      OP_ADDIU:     return C_ADDIU;
      default:      return C_ILL;
    endcase
  endfunction

  // Step list of each instruction: index 0 is fetch, 1 is decode.
  function automatic phase_t phaseOf(cls_t c, int idx);
    if (idx == 0) return PH_F;
    if (idx == 1) return PH_D;
    case (c)
      C_R:     return (idx == 2) ? PH_EX  : PH_RWB;
      C_ADDIU: return (idx == 2) ? PH_IEX : PH_IWB;
      C_LW:    return (idx == 2) ? PH_A : ((idx == 3) ? PH_RD : PH_LWB);
      C_SW:    return (idx == 2) ? PH_A : PH_WR;
      C_BEQ:   return PH_BR;
      C_J:     return PH_JMP;
      default: return PH_TRAP;
    endcase
  endfunction

  function automatic int seqLen(cls_t c);
    case (c)
      C_BEQ, C_J:          return 3;
      C_R, C_ADDIU, C_SW:  return 4;
      C_LW:                return 5;
      default:             return 0;
    endcase
  endfunction

  function automatic int advance(cls_t c, int idx, logic rdy);
    phase_t p = phaseOf(c, idx);
    if (p == PH_TRAP) return idx;
    if ((p == PH_F || p == PH_RD || p == PH_WR) && !rdy) return idx;
    if (idx + 1 == seqLen(c)) return 0;
    return idx + 1;
  endfunction

  function automatic strobes_t expStrobes(phase_t p, logic rdy, logic z);
    strobes_t e = '0;
    case (p)
      PH_F:    begin e.req = 1'b1; e.ir = rdy; e.pcw = rdy; end
      PH_RD:   begin e.req = 1'b1; e.iord = 1'b1; e.mdr = rdy; end
      PH_LWB:  begin e.rf = 1'b1; e.dm = 1'b1; end
      PH_WR:   begin e.req = 1'b1; e.wen = 1'b1; e.wstrb = 4'hF; e.iord = 1'b1; end
      PH_RWB:  begin e.rf = 1'b1; e.dst = 1'b1; end
      PH_IWB:  e.rf = 1'b1;
      PH_BR:   begin e.pcs = 2'b01; e.pcw = z; end
      PH_JMP:  begin e.pcw = 1'b1; e.pcs = 2'b10; end
      PH_TRAP: e.ill = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // {care, src_a, src_b, op}
  function automatic logic [5:0] expAlu(phase_t p);
    case (p)
      PH_F:          return {1'b1, 1'b0, 2'b01, 2'b00};
      PH_D:          return {1'b1, 1'b0, 2'b11, 2'b00};
      PH_A, PH_IEX:  return {1'b1, 1'b1, 2'b10, 2'b00};
      PH_EX:         return {1'b1, 1'b1, 2'b00, 2'b10};
      PH_BR:         return {1'b1, 1'b1, 2'b00, 2'b01};
      default:       return 6'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic rdy, input logic z);
    @(posedge clk);
    #1;
    rst = r; opcode = op; memReady = rdy; aluZero = z;
  endtask

  // Reference model: walks each instruction's step list, stalling memory steps until ready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mIdx <= 0; mRetired <= '0; mCls <= C_R;
    end else begin
      mCls <= (mIdx == 1) ? classify(opcode) : mCls;
      mIdx <= advance((mIdx == 1) ? classify(opcode) : mCls, mIdx, memReady);
      if (mIdx != 0 && advance((mIdx == 1) ? classify(opcode) : mCls, mIdx, memReady) == 0)
        mRetired <= mRetired + 32'd1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    strobes_t act, e;
    phase_t p;
    logic [5:0] a;
    forever begin
      @(negedge clk);
      act = {memIf.mem_req, memIf.mem_wen, memIf.mem_wstrb, memIf.mem_iord, irWen, mdrWen,
             pcWen, pcSrc, rfWen, rfDst, rfDataMem, illegal};
      if (rst) begin
        checkOutput("reset_strobes", 32'(act), 32'd0);
        checkOutput("reset_state", 32'(stateDbg), 32'd0);
        checkOutput("reset_retired", retired, 32'd0);
      end else begin
        p = phaseOf(mCls, mIdx);
        e = expStrobes(p, memReady, aluZero);
        checkOutput("strobes", 32'(act), 32'(e));
        a = expAlu(p);
        if (a[5]) checkOutput("alu_ctrl", 32'({aluSrcA, aluSrcB, aluOp}), 32'(a[4:0]));
        checkOutput("state_is_fetch", 32'(stateDbg == 4'd0), 32'(p == PH_F));
        checkOutput("retired", retired, mRetired);
      end
    end
  end

  // Runs one instruction: fw ready-low cycles in fetch, mw in the data access.
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input logic z,
                          output int cycles, output int irCnt, output int mdrCnt,
                          output int rfCnt, output int pcCnt, output int wenCnt,
                          output int retDelta);
    logic [31:0] startRet;
    bit left, done;
    logic rdy;
    startRet = retired;
    left = 0; done = 0; cycles = -1; retDelta = -1;
    irCnt = 0; mdrCnt = 0; rfCnt = 0; pcCnt = 0; wenCnt = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      rdy = !((c < fw) || (c >= fw + 3 && c < fw + 3 + mw));
      applyStimulus(1'b0, op, rdy, z);
      @(negedge clk);
      if (stateDbg != 4'd0) left = 1;
      else if (left) begin
        done = 1; cycles = c; retDelta = int'(retired - startRet);
        #1 memReady = 1'b0;
      end
      if (!done) begin
        irCnt += int'(irWen); mdrCnt += int'(mdrWen); rfCnt += int'(rfWen);
        pcCnt += int'(pcWen); wenCnt += int'(memIf.mem_wen);
      end
    end
    checkOutput("instr_done", 32'(done), 32'd1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t expected below 300000", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, ir, mdr, rf, pc, wen, rd, reqCnt, trapRun;
    logic [31:0] startRet;
    phase_t p;

    // Reset and first fetch.
    applyStimulus(1'b1, OP_ADDIU, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_ADDIU, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("rst_mem_req", 32'(memIf.mem_req), 32'd0);
    checkOutput("rst_retired", retired, 32'd0);

    // addiu, zero-wait.
    runInstr(OP_ADDIU, 0, 0, 1'b0, cyc, ir, mdr, rf, pc, wen, rd);
    checkOutput("addiu_cycles", 32'(cyc), 32'd4);
    checkOutput("addiu_rf_wen", 32'(rf), 32'd1);
    checkOutput("addiu_retired", retired, 32'd1);

    // lw with 2 fetch waits and 3 read waits.
    runInstr(OP_LW, 2, 3, 1'b0, cyc, ir, mdr, rf, pc, wen, rd);
    checkOutput("lw_cycles", 32'(cyc), 32'd10);
    checkOutput("lw_ir_wen", 32'(ir), 32'd1);
    checkOutput("lw_mdr_wen", 32'(mdr), 32'd1);
    checkOutput("lw_retired_delta", 32'(rd), 32'd1);

    // sw with 2 write waits.
    runInstr(OP_SW, 0, 2, 1'b0, cyc, ir, mdr, rf, pc, wen, rd);
    checkOutput("sw_cycles", 32'(cyc), 32'd6);
    checkOutput("sw_wen_cycles", 32'(wen), 32'd3);
    checkOutput("sw_rf_wen", 32'(rf), 32'd0);

    // beq taken then not taken.
    runInstr(OP_BEQ, 0, 0, 1'b1, cyc, ir, mdr, rf, pc, wen, rd);
    checkOutput("beq_taken_cycles", 32'(cyc), 32'd3);
    checkOutput("beq_taken_pc_wen", 32'(pc), 32'd2);
    runInstr(OP_BEQ, 0, 0, 1'b0, cyc, ir, mdr, rf, pc, wen, rd);
    checkOutput("beq_nt_cycles", 32'(cyc), 32'd3);
    checkOutput("beq_nt_pc_wen", 32'(pc), 32'd1);
    checkOutput("beq_nt_retired_delta", 32'(rd), 32'd1);

    // jump and R-type.
    runInstr(OP_J, 0, 0, 1'b0, cyc, ir, mdr, rf, pc, wen, rd);
    checkOutput("j_cycles", 32'(cyc), 32'd3);
    checkOutput("j_pc_wen", 32'(pc), 32'd2);
    runInstr(OP_R, 1, 0, 1'b0, cyc, ir, mdr, rf, pc, wen, rd);
    checkOutput("r_cycles", 32'(cyc), 32'd5);
    checkOutput("retired_total", retired, 32'd7);

    // Asynchronous reset in the middle of a stalled store.
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, OP_SW, (c < 3), 1'b0);
    @(negedge clk);
    checkOutput("memwr_wen", 32'(memIf.mem_wen), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_req", 32'(memIf.mem_req), 32'd0);
    checkOutput("async_rst_wen", 32'(memIf.mem_wen), 32'd0);
    checkOutput("async_rst_state", 32'(stateDbg), 32'd0);
    checkOutput("async_rst_retired", retired, 32'd0);
    applyStimulus(1'b1, OP_SW, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fetch_resume_req", 32'(memIf.mem_req), 32'd1);

    // Unsupported opcode lands in TRAP and stays there.
    startRet = retired;
    applyStimulus(1'b0, 6'h3f, 1'b1, 1'b0);
    applyStimulus(1'b0, 6'h3f, 1'b1, 1'b0);
    applyStimulus(1'b0, 6'h3f, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("trap_illegal", 32'(illegal), 32'd1);
    reqCnt = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 6'h3f, 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      reqCnt += int'(memIf.mem_req);
    end
    checkOutput("trap_no_req", 32'(reqCnt), 32'd0);
    checkOutput("trap_retired", retired, startRet);
    checkOutput("trap_still_illegal", 32'(illegal), 32'd1);
    applyStimulus(1'b1, OP_R, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_clears_illegal", 32'(illegal), 32'd0);

    // Randomized traffic; the per-cycle comparison does the checking.
    trapRun = 0;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      p = phaseOf(mCls, mIdx);
      trapRun = (p == PH_TRAP && !rst) ? trapRun + 1 : 0;
      rst = (trapRun > 4) || ($urandom_range(0, 199) == 0);
      if (p == PH_F) begin
        case ($urandom_range(0, 29))
          0:       opcode = 6'($urandom);
          1, 2, 3, 4, 5:    opcode = OP_R;
          6, 7, 8, 9, 10:   opcode = OP_LW;
          11, 12, 13, 14, 15: opcode = OP_SW;
          16, 17, 18, 19, 20: opcode = OP_BEQ;
          21, 22, 23, 24:   opcode = OP_J;
          default: opcode = OP_ADDIU;
        endcase
      end
      memReady = ($urandom_range(0, 3) != 0);
      aluZero  = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
